// File: rtl/ov7670_gray_downscaler_if.sv
// rtl/ov7670_gray_downscaler_if.sv - camera byte bus in, averaged gray pixel stream out
interface ov7670_gray_downscaler_if;
  logic        vsync;
  logic        href;
  logic [7:0]  data_in;
  logic        capture_en;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic [14:0] pix_addr;
  logic        frame_start;
  logic        frame_done;
  logic        frame_abort;

  modport master (
    output vsync, href, data_in, capture_en,
    input  pix_valid, pix_data, pix_x, pix_y, pix_addr,
    input  frame_start, frame_done, frame_abort
  );

  modport slave (
    input  vsync, href, data_in, capture_en,
    output pix_valid, pix_data, pix_x, pix_y, pix_addr,
    output frame_start, frame_done, frame_abort
  );
endinterface

// File: rtl/ov7670_gray_downscaler.sv
// rtl/ov7670_gray_downscaler.sv - RGB565 camera stream to 4x4 box-averaged 8-bit gray pixels
module ov7670_gray_downscaler #(
  parameter int H_IN  = 640,
  parameter int V_IN  = 480,
  parameter int SHIFT = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  ov7670_gray_downscaler_if.slave bus
);
  localparam int OUT_W = H_IN >> SHIFT;
  localparam int XW    = $clog2(H_IN + 1);
  localparam int YW    = $clog2(V_IN + 1);
  localparam int BXW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int HSW   = 8 + SHIFT;
  localparam int ACW   = 8 + 2 * SHIFT;

  typedef enum logic [1:0] {IDLE, ACTIVE, SKIP} state_t;

  logic       vsync_r, vsync_d, href_r, href_d, cap_r;
  logic [7:0] data_r;
  logic       phase;
  logic [7:0] byte_hi;
  logic       y_valid;
  logic [7:0] y_val;

  state_t         state;
  logic [XW-1:0]  in_x;
  logic [YW-1:0]  in_y;
  logic [HSW-1:0] hacc;
  logic [ACW-1:0] line_buf [OUT_W];

  logic [7:0]  r8, g8, b8;
  logic [5:0]  g6;
  logic [10:0] ysum;

  assign r8   = {byte_hi[7:3], byte_hi[7:5]};
  assign g6   = {byte_hi[2:0], data_r[7:5]};
  assign g8   = {g6, g6[5:4]};
  assign b8   = {data_r[4:0], data_r[4:2]};
  assign ysum = {2'b00, r8, 1'b0} + 11'(g8) * 11'd5 + {3'b000, b8};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_r <= 1'b0;
      vsync_d <= 1'b0;
      href_r  <= 1'b0;
      href_d  <= 1'b0;
      cap_r   <= 1'b0;
      data_r  <= '0;
      phase   <= 1'b0;
      byte_hi <= '0;
      y_valid <= 1'b0;
      y_val   <= '0;
    end else begin
      vsync_r <= bus.vsync;
      vsync_d <= vsync_r;
      href_r  <= bus.href;
      href_d  <= href_r;
      cap_r   <= bus.capture_en;
      data_r  <= bus.data_in;
      y_valid <= 1'b0;
      // a pixel is complete on every second byte of a line; an odd trailing byte never pairs
      if (!href_r) begin
        phase <= 1'b0;
      end else if (!phase) begin
        byte_hi <= data_r;
        phase   <= 1'b1;
      end else begin
        phase   <= 1'b0;
        y_valid <= 1'b1;
        y_val   <= ysum[10:3];
      end
    end
  end

  logic             vsync_fall, vsync_rise, href_fall;
  logic             x_ok, pix_ok, blk_end, last_row, last_pix, lines_done;
  logic [SHIFT-1:0] row;
  logic [BXW-1:0]   idx;
  logic [HSW-1:0]   hsum;
  logic [ACW-1:0]   total;

  assign vsync_fall = vsync_d & ~vsync_r;
  assign vsync_rise = ~vsync_d & vsync_r;
  assign href_fall  = href_d & ~href_r;
  assign row        = in_y[SHIFT-1:0];
  assign idx        = in_x[SHIFT +: BXW];
  assign x_ok       = y_valid && (state == ACTIVE) && (in_x < XW'(H_IN));
  assign pix_ok     = x_ok && (in_y < YW'(V_IN));
  assign blk_end    = (in_x[SHIFT-1:0] == '1);
  assign last_row   = (row == '1);
  assign hsum       = hacc + HSW'(y_val);
  assign total      = line_buf[idx] + ACW'(hsum);
  assign last_pix   = (in_y == YW'(V_IN - 1)) && (in_x == XW'(H_IN - 1));
  assign lines_done = (in_y == YW'(V_IN)) || (href_fall && in_y == YW'(V_IN - 1));

  always_ff @(posedge clk) begin
    if (pix_ok && blk_end && !last_row)
      line_buf[idx] <= (row == '0) ? ACW'(hsum) : total;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      in_x            <= '0;
      in_y            <= '0;
      hacc            <= '0;
      bus.pix_valid   <= 1'b0;
      bus.pix_data    <= '0;
      bus.pix_x       <= '0;
      bus.pix_y       <= '0;
      bus.pix_addr    <= '0;
      bus.frame_start <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.frame_abort <= 1'b0;
    end else begin
      bus.pix_valid   <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (vsync_fall) begin
            in_x <= '0;
            in_y <= '0;
            hacc <= '0;
            if (cap_r) begin
              state           <= ACTIVE;
              bus.frame_start <= 1'b1;
            end else begin
              state <= SKIP;
            end
          end
        end
        SKIP: begin
          if (vsync_rise)
            state <= IDLE;
        end
        ACTIVE: begin
          if (x_ok) begin
            in_x <= in_x + XW'(1);
            hacc <= blk_end ? '0 : hsum;
          end
          if (pix_ok && blk_end && last_row) begin
            bus.pix_valid  <= 1'b1;
            bus.pix_data   <= total[2*SHIFT +: 8];
            bus.pix_x      <= 8'(in_x >> SHIFT);
            bus.pix_y      <= 7'(in_y >> SHIFT);
            bus.pix_addr   <= 15'(in_y >> SHIFT) * 15'(OUT_W) + 15'(in_x >> SHIFT);
            bus.frame_done <= last_pix;
          end
          if (href_fall) begin
            in_x <= '0;
            hacc <= '0;
            if (in_y < YW'(V_IN))
              in_y <= in_y + YW'(1);
          end
          // done was already pulsed with the last pixel; only a short frame reports here
          if (vsync_rise) begin
            state <= IDLE;
            if (!lines_done)
              bus.frame_abort <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ov7670_gray_downscaler.sv
// tb/tb_ov7670_gray_downscaler.sv - randomized frames against a block-average reference model
module tb_ov7670_gray_downscaler;
  localparam int H  = 32;
  localparam int V  = 16;
  localparam int OW = H / 4;
  localparam int OH = V / 4;

  typedef struct {
    int data;
    int x;
    int y;
    int addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ov7670_gray_downscaler_if bus ();

  ov7670_gray_downscaler #(.H_IN(H), .V_IN(V), .SHIFT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] fpix [V+2][H+2];
  int          gray_rgb [256];
  exp_t        exp_q [$];
  exp_t        mon_e;
  int          n_start, n_done, n_abort, n_strobe, last_addr;
  bit          lat_on = 0;
  int          lat_edge = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int luma(input logic [15:0] p);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(p[15:11]);
    g6 = int'(p[10:5]);
    b5 = int'(p[4:0]);
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return (2 * r8 + 5 * g8 + b8) / 8;
  endfunction

  function automatic int block_avg(input int j, input int k);
    int s = 0;
    for (int dy = 0; dy < 4; dy++)
      for (int dx = 0; dx < 4; dx++)
        s += luma(fpix[4*j+dy][4*k+dx]);
    return s / 16;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pix_valid) begin
        n_strobe++;
        last_addr = int'(bus.pix_addr);
        if (exp_q.size() == 0) begin
          chk("unexpected_pix", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pix_data", int'(bus.pix_data), mon_e.data);
          chk("pix_x", int'(bus.pix_x), mon_e.x);
          chk("pix_y", int'(bus.pix_y), mon_e.y);
          chk("pix_addr", int'(bus.pix_addr), mon_e.addr);
          if (lat_on && mon_e.addr == 0)
            chk("latency", cyc, lat_edge + 2);
        end
      end
      if (bus.frame_start) n_start++;
      if (bus.frame_abort) n_abort++;
      if (bus.frame_done) begin
        n_done++;
        chk("done_with_last", int'(bus.pix_valid && exp_q.size() == 0), 1);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.href    = 1'b0;
      bus.data_in = 8'h00;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pix_valid"}, int'(bus.pix_valid), 0);
    chk({tag, "_pix_data"}, int'(bus.pix_data), 0);
    chk({tag, "_pix_x"}, int'(bus.pix_x), 0);
    chk({tag, "_pix_y"}, int'(bus.pix_y), 0);
    chk({tag, "_pix_addr"}, int'(bus.pix_addr), 0);
    chk({tag, "_frame_start"}, int'(bus.frame_start), 0);
    chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
    chk({tag, "_frame_abort"}, int'(bus.frame_abort), 0);
  endtask

  task automatic fill_const(input logic [15:0] p);
    for (int r = 0; r < V + 2; r++)
      for (int c = 0; c < H + 2; c++)
        fpix[r][c] = p;
  endtask

  task automatic fill_random();
    for (int r = 0; r < V + 2; r++)
      for (int c = 0; c < H + 2; c++)
        fpix[r][c] = 16'($urandom);
  endtask

  // rst_at >= 0 pulses reset before that line is sent
  task automatic run_frame(input string tag, input int lines, input int ppl, input bit odd,
                           input bit cap, input int rst_at);
    int          got_lines;
    int          n_exp;
    logic [15:0] p;
    got_lines = (rst_at >= 0 && rst_at < lines) ? rst_at : lines;
    n_exp = 0;
    if (cap)
      for (int j = 0; j < OH; j++)
        if (4 * j + 3 < got_lines)
          for (int k = 0; k < OW; k++) begin
            exp_q.push_back('{block_avg(j, k), k, j, j * OW + k});
            n_exp++;
          end
    n_start = 0; n_done = 0; n_abort = 0; n_strobe = 0; last_addr = -1;
    @(posedge clk);
    #1;
    bus.vsync      = 1'b0;
    bus.capture_en = cap;
    idle(4);
    for (int l = 0; l < lines; l++) begin
      if (l == rst_at) begin
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero({tag, "_midrst"});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      for (int c = 0; c < ppl; c++) begin
        p = fpix[l][c];
        @(posedge clk);
        #1;
        bus.href    = 1'b1;
        bus.data_in = p[15:8];
        @(posedge clk);
        #1;
        bus.data_in = p[7:0];
        if (lat_on && l == 3 && c == 3) lat_edge = cyc + 1;
      end
      if (odd) begin
        @(posedge clk);
        #1;
        bus.href    = 1'b1;
        bus.data_in = 8'hA5;
      end
      idle(8);
    end
    idle(4);
    bus.vsync = 1'b1;
    idle(12);
    chk({tag, "_strobes"}, n_strobe, n_exp);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_start"}, n_start, int'(cap));
    chk({tag, "_done"}, n_done, int'(cap && rst_at < 0 && lines >= V));
    chk({tag, "_abort"}, n_abort, int'(cap && rst_at < 0 && lines < V));
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    bus.vsync      = 1'b1;
    bus.href       = 1'b0;
    bus.data_in    = 8'h00;
    bus.capture_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    idle(5);

    chk("model_white", luma(16'hFFFF), 255);
    chk("model_red", luma(16'hF800), 63);
    chk("model_green", luma(16'h07E0), 159);
    chk("model_blue", luma(16'h001F), 31);

    for (int i = 0; i < 256; i++) gray_rgb[i] = -1;
    for (int p = 0; p < 65536; p++)
      if (gray_rgb[luma(16'(p))] < 0) gray_rgb[luma(16'(p))] = p;

    fill_const(16'hFFFF);
    run_frame("white", V, H, 0, 1, -1);
    chk("white_last_addr", last_addr, OW * OH - 1);
    fill_const(16'hF800);
    run_frame("red", V, H, 0, 1, -1);
    fill_const(16'h07E0);
    run_frame("green", V, H, 0, 1, -1);
    fill_const(16'h001F);
    run_frame("blue", V, H, 0, 1, -1);

    fill_const(16'h0000);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        chk("gray_found", int'(gray_rgb[16 * (x + 4 * y)] >= 0), 1);
        fpix[y][x] = 16'(gray_rgb[16 * (x + 4 * y)]);
      end
    chk("model_block0", block_avg(0, 0), 120);
    lat_on = 1;
    run_frame("block0", V, H, 0, 1, -1);
    lat_on = 0;

    fill_random();
    run_frame("abort8", 8, H, 0, 1, -1);
    fill_random();
    run_frame("after_abort", V, H, 0, 1, -1);
    fill_random();
    run_frame("skip", V, H, 0, 0, -1);
    fill_random();
    run_frame("after_skip", V, H, 0, 1, -1);
    fill_random();
    run_frame("wide", V + 2, H + 2, 1, 1, -1);
    fill_random();
    run_frame("midrst", V, H, 0, 1, 8);
    fill_random();
    run_frame("after_rst", V, H, 0, 1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
